// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the shared-bus select arbiter.
// Imported by the arbiter top and its priority-pick helper.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ    = 3;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first unmasked request at or above ptr,
// wrapping modulo N_REQ, returned as one-hot, binary index and found flag.
module rr_priority_pick
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0] pick_idx,
  output logic             found
);

  logic [N_REQ-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = req[gi] & ~mask[gi];
    end
  endgenerate

  // Walk outward from ptr; the first candidate met keeps the grant.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx_v;
    pick_onehot = '0;
    pick_idx    = '0;
    found       = 1'b0;
    pos         = 0;
    idx_v       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx_v = IDX_W'(pos);
      if (!found && cand[idx_v]) begin
        found              = 1'b1;
        pick_idx           = idx_v;
        pick_onehot[idx_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Round-robin owner arbiter driving one-hot mux selects for a shared bus.
// Tenures end on release, owner request drop, or a MAX_HOLD-cycle timeout.
module bus_select_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             release_i,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam int               CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_reg, state_next;
  logic [N_REQ-1:0] sel_reg, sel_next;
  logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
  logic             busy_reg, busy_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;

  logic             rel_ev;
  logic             lim_ev;
  logic [IDX_W-1:0] ptr_wrap;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_owner
      assign owner_oh[gi] = (grant_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // An owner dropping its request is handled exactly like an explicit release.
  assign rel_ev   = release_i | ~req[grant_idx_reg];
  assign lim_ev   = (cnt_reg == CNT_LAST);
  assign ptr_wrap = (grant_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;

  // While busy the pick already looks ahead with the post-tenure pointer,
  // so a handover costs no idle cycle.
  assign pick_ptr  = (state_reg == BUSY) ? ptr_wrap : ptr_reg;
  assign pick_mask = ((state_reg == BUSY) && rel_ev) ? owner_oh : '0;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (req),
    .ptr         (pick_ptr),
    .mask        (pick_mask),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .found       (pick_found)
  );

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    grant_idx_next = grant_idx_reg;
    busy_next      = busy_reg;
    timeout_next   = 1'b0;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          sel_next       = pick_onehot;
          grant_idx_next = pick_idx;
          busy_next      = 1'b1;
          cnt_next       = '0;
          state_next     = BUSY;
        end else begin
          sel_next  = '0;
          busy_next = 1'b0;
        end
      end
      BUSY: begin
        if (rel_ev || lim_ev) begin
          ptr_next     = ptr_wrap;
          timeout_next = lim_ev & ~rel_ev;
          cnt_next     = '0;
          if (pick_found) begin
            sel_next       = pick_onehot;
            grant_idx_next = pick_idx;
          end else begin
            sel_next   = '0;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        sel_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      grant_idx_reg <= '0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      grant_idx_reg <= grant_idx_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign sel       = sel_reg;
  assign grant_idx = grant_idx_reg;
  assign busy      = busy_reg;
  assign timeout   = timeout_reg;

endmodule
